divider_restoring_param: RTL
============================

Name: divider_restoring_param

Overview:
Parametrised, fixed-latency, restoring shift-subtract divider. Successor to the team's repeated-subtraction 8-bit divider: same Start/Ack/CEN handshake and one-hot state outputs, but width is generic, latency is a constant WIDTH compute steps independent of operand values, and divide-by-zero is detected and flagged. Sits in lab datapaths behind a control FSM or a push-button/DigiTerm front end.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), step-counter width (derived, not to be overridden)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Xin  input  WIDTH  dividend
Yin  input  WIDTH  divisor
Start  input  1  request; sampled only in INITIAL
Ack  input  1  result acknowledge; sampled only in DONE_S
CEN  input  1  clock enable for COMPUTE steps only
Done  output  1  high exactly while in DONE_S
Quotient  output  WIDTH  quotient register
Remainder  output  WIDTH  remainder register
DivByZero  output  1  high in DONE_S when Yin was 0 at Start
Qi, Qc, Qd  output  1 each  one-hot state: INITIAL, COMPUTE, DONE_S

Behaviour:
- One clock (Clk); asynchronous active-high Reset. Reset: state=INITIAL (Qi=1,Qc=0,Qd=0), Done=0, Quotient=0, Remainder=0, DivByZero=0, step counter=0, internal dividend/divisor registers=0.
- States (one-hot, 3'b001/010/100): INITIAL, COMPUTE, DONE_S. Illegal encodings recover to INITIAL next edge.
- INITIAL: outputs hold previous result. On edge with Start=1: capture Xin, Yin; clear Quotient, Remainder, counter.
  - If Yin==0: go directly to DONE_S; Quotient=all ones, Remainder=Xin, DivByZero=1. Done rises 1 cycle after Start edge.
  - Else: DivByZero=0, go to COMPUTE.
  - Ack ignored in INITIAL; Start+Ack together = Start only.
- COMPUTE: each edge with CEN=1 performs one step; CEN=0 holds all state/registers.
  - Step: partial remainder P (WIDTH+1 bits internal) = {Remainder, dividend MSB}; dividend shifts left; if P >= divisor: Remainder=P-divisor, shift 1 into Quotient LSB; else Remainder=P[WIDTH-1:0], shift 0.
  - Exactly WIDTH enabled steps; on the edge performing step WIDTH, state->DONE_S. Done high from the following cycle. Latency = WIDTH CEN-high cycles + 1 start cycle.
  - Start, Ack ignored.
- DONE_S: Quotient/Remainder/DivByZero stable. Edge with Ack=1 -> INITIAL (Done falls next cycle). Start ignored. CEN does not gate INITIAL or DONE_S.
- Result: Xin = Quotient*Yin + Remainder, Remainder < Yin, unsigned (unless signed mode).
- Reset asserted mid-COMPUTE or in DONE_S: immediate return to reset values; no partial result retained.

Optional Feature:
DIVIDER_SIGNED_EN: when defined, operands and results are two's complement. Divide on magnitudes, quotient truncates toward zero, Remainder takes dividend's sign, quotient negated if operand signs differ. Sign fix-up applied on the final step edge (no extra cycle). Overflow case (-2^(WIDTH-1))/(-1): Quotient=-2^(WIDTH-1), Remainder=0, DivByZero=0. Divide-by-zero: Quotient=all ones, Remainder=Xin. When undefined: unsigned only, no sign logic synthesised.

Test Plan:
- WIDTH=8, Xin=200, Yin=7, Start 1 cycle, CEN=1 -> Done after 8 compute edges; Quotient=28, Remainder=4, DivByZero=0; Ack -> Qi=1 next cycle.
- Xin=5, Yin=0, Start -> DONE_S next edge; Quotient=8'hFF, Remainder=5, DivByZero=1; Qc never high.
- Xin=255, Yin=1 with CEN toggling 1/0 each cycle -> Done after 16 compute clocks; Quotient=255, Remainder=0; values frozen on CEN=0 cycles.
- Xin=3, Yin=9 -> Quotient=0, Remainder=3 after 8 steps; Start held high during COMPUTE/DONE_S causes no restart; Ack held low keeps Done=1 indefinitely.
- Reset pulsed during step 4 of 100/3 -> Qi=1, Quotient=0, Remainder=0, Done=0 immediately; subsequent 100/3 -> 33 r 1.
- DIVIDER_SIGNED_EN, WIDTH=8: -7/2 -> Quotient=8'hFD, Remainder=8'hFF; -128/-1 -> Quotient=8'h80, Remainder=0.

Source files
------------

// File: rtl/divider_restoring_param.sv
// -----------------------------------------------------------------------------
// divider_restoring_param
//
// Fixed-latency restoring shift-subtract divider with a Start/Ack/CEN
// handshake and one-hot state outputs. A non-zero divide takes one start
// edge plus WIDTH CEN-enabled compute edges. Divide-by-zero skips COMPUTE
// and is flagged on DivByZero.
//
// Optional feature (compile-time macro):
//   DIVIDER_SIGNED_EN - two's complement operands and results. The divide
//                       runs on magnitudes. The quotient truncates toward
//                       zero and the remainder takes the dividend's sign.
//                       The sign fix-up is applied on the final step edge.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   Xin        in   dividend (WIDTH)
//   Yin        in   divisor  (WIDTH)
//   Start      in   request, sampled only in INITIAL
//   Ack        in   result acknowledge, sampled only in DONE_S
//   CEN        in   step enable, only gates COMPUTE
//   Done       out  high while in DONE_S
//   Quotient   out  quotient register (WIDTH)
//   Remainder  out  remainder register (WIDTH)
//   DivByZero  out  divisor was zero at Start
//   Qi/Qc/Qd   out  one-hot state: INITIAL / COMPUTE / DONE_S
//
// States:
//   S_INIT | idle, previous result held, waiting for Start
//   S_COMP | one shift-subtract step per CEN-high edge, WIDTH steps total
//   S_DONE | result stable, waiting for Ack
// -----------------------------------------------------------------------------
module divider_restoring_param #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Xin,
    input  logic [WIDTH-1:0] Yin,
    input  logic             Start,
    input  logic             Ack,
    input  logic             CEN,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero,
    output logic             Qi,
    output logic             Qc,
    output logic             Qd
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_INIT = 3'b001,
        S_COMP = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] x_mag, y_mag;
    logic [WIDTH:0]   part;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] quot_step, rem_step;
    logic [WIDTH-1:0] quot_fin, rem_fin;

`ifdef DIVIDER_SIGNED_EN
    logic negq_q, negq_d;
    logic negr_q, negr_d;

    assign x_mag    = Xin[WIDTH-1] ? -Xin : Xin;
    assign y_mag    = Yin[WIDTH-1] ? -Yin : Yin;
    assign quot_fin = negq_q ? -quot_step : quot_step;
    assign rem_fin  = negr_q ? -rem_step : rem_step;
`else
    assign x_mag    = Xin;
    assign y_mag    = Yin;
    assign quot_fin = quot_step;
    assign rem_fin  = rem_step;
`endif

    // Restoring step: the partial remainder is always below the divisor, so
    // the difference fits back into WIDTH bits whenever ge is set.
    assign part      = {rem_q, dvd_q[WIDTH-1]};
    assign diff      = part - {1'b0, dvs_q};
    assign ge        = (part >= {1'b0, dvs_q});
    assign rem_step  = ge ? diff[WIDTH-1:0] : part[WIDTH-1:0];
    assign quot_step = {quot_q[WIDTH-2:0], ge};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            S_INIT: begin
                if (Start) begin
                    dvd_d  = x_mag;
                    dvs_d  = y_mag;
                    quot_d = '0;
                    rem_d  = '0;
                    cnt_d  = '0;
`ifdef DIVIDER_SIGNED_EN
                    negq_d = Xin[WIDTH-1] ^ Yin[WIDTH-1];
                    negr_d = Xin[WIDTH-1];
`endif
                    if (Yin == '0) begin
                        quot_d  = '1;
                        rem_d   = Xin;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = S_COMP;
                    end
                end
            end
            S_COMP: begin
                if (CEN) begin
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        quot_d  = quot_fin;
                        rem_d   = rem_fin;
                        state_d = S_DONE;
                    end else begin
                        quot_d  = quot_step;
                        rem_d   = rem_step;
                    end
                end
            end
            S_DONE: begin
                if (Ack) state_d = S_INIT;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_INIT;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign Qi        = (state_q == S_INIT);
    assign Qc        = (state_q == S_COMP);
    assign Qd        = (state_q == S_DONE);
    assign Done      = Qd;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivByZero = dbz_q;

endmodule
